rk8e_data_break: RTL



---
 rtl/rk8e_data_break.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rk8e_data_break.sv
// RK8-E data-break engine: steals one memory cycle from the CPU per controller request.
// Optional DB_WATCHDOG_EN adds a grant watchdog with a sticky break_err.
module rk8e_data_break #(
    parameter int MEM_RD_LAT  = 1,
    parameter int GNT_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        data_break,
    input  logic        to_disk,
    input  logic [0:14] dmaAddr,
    input  logic [0:11] dmaDOUT,
    input  logic        cpu_break_ok,
    output logic        break_req,
    output logic        break_in_prog,
    output logic        db1,
    output logic [0:14] mem_addr,
    output logic [0:11] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [0:11] mem_rdata,
    output logic [0:11] dmaDIN,
    output logic        break_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_DB1  = 3'd2,
        S_DB2  = 3'd3,
        S_DB3  = 3'd4
    } state_t;

    generate
        if (MEM_RD_LAT < 1 || MEM_RD_LAT > 7 || GNT_TIMEOUT < 1 || GNT_TIMEOUT > 4095) begin : g_bad_param
            $error("rk8e_data_break: parameter out of range");
        end
    endgenerate

    state_t      r_state;
    state_t      w_next;
    logic        w_grant;
    logic        w_timeout;
    logic [0:14] r_addr;
    logic [0:11] r_data;
    logic        r_dir;
    logic [2:0]  r_lat;
    logic [0:11] r_din;

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            S_IDLE: if (data_break && !clear) w_next = S_REQ;
            S_REQ: begin
                if (clear) begin
                    w_next = S_IDLE;
                end else if (cpu_break_ok) begin
                    w_next  = S_DB1;
                    w_grant = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            // clear is deliberately ignored once memory is owned
            S_DB1:   w_next = r_dir ? S_DB2 : S_DB3;
            S_DB2:   if (r_lat == 3'd0) w_next = S_DB3;
            S_DB3:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_lat   <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_addr <= dmaAddr;
                r_data <= dmaDOUT;
                r_dir  <= to_disk;
            end
            // r_lat counts remaining DB2 clocks before mem_rdata is valid
            if (r_state == S_DB1) begin
                r_lat <= 3'(MEM_RD_LAT - 1);
            end else if (r_state == S_DB2 && r_lat != 3'd0) begin
                r_lat <= r_lat - 3'd1;
            end
            if (r_state == S_DB2 && r_lat == 3'd0) r_din <= mem_rdata;
        end
    end

`ifdef DB_WATCHDOG_EN
    logic [11:0] r_wdog;
    logic        r_err;

    assign w_timeout = (r_state == S_REQ) && (r_wdog == 12'(GNT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == S_REQ && w_next == S_REQ) ? r_wdog + 12'd1 : 12'd0;
            if (r_state == S_REQ && !clear && !cpu_break_ok && w_timeout) r_err <= 1'b1;
        end
    end

    assign break_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign break_err = 1'b0;
`endif

    assign break_req     = (r_state == S_REQ);
    assign break_in_prog = (r_state == S_DB1) || (r_state == S_DB2) || (r_state == S_DB3);
    assign db1           = (r_state == S_DB1);
    assign mem_we        = (r_state == S_DB1) && !r_dir;
    assign mem_re        = (r_state == S_DB1) && r_dir;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_data;
    assign dmaDIN        = r_din;

endmodule
